instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to an always-ready
// instruction memory, buffers the responses in a small FIFO and hands them to
// the decoder in order. A redirect flushes everything outstanding and restarts
// fetching at the new target.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Fetch state
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic            r_inflight;

  // Prefetch buffer
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [XLEN-1:0]  r_buf_data [DEPTH];
  logic [XLEN-1:0]  r_buf_pc   [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_used;
  logic             w_unused_low_bits;

  // Entries already buffered plus the one response still on its way; a new
  // request is only issued when it is guaranteed a free slot on arrival.
  assign w_used = r_count + CNT_W'(r_inflight);

  assign imem_req  = !rst && !redirect_valid && (w_used < DEPTH_C);
  assign imem_addr = r_fetch_pc;

  // A response is killed by a redirect or reset in the cycle it arrives.
  assign w_push = r_inflight && !rst && !redirect_valid;

  // Redirect and reset suppress the handshake so nothing stale is consumed.
  assign instr_valid = !rst && !redirect_valid && (r_count != '0);
  assign w_pop       = instr_valid && instr_ready;

  assign instr    = r_buf_data[r_head];
  assign instr_pc = r_buf_pc[r_head];

  // Redirect target is forced to word alignment, so its low bits are dropped.
  assign w_unused_low_bits = ^redirect_pc[1:0];

  // Fetch PC, in-flight tracking, and FIFO pointers/occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_resp_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage: capture the returning word and its address at the tail
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_tail] <= imem_rdata;
      r_buf_pc[r_tail]   <= r_resp_pc;
    end
  end

  // The credit check must make a push into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A queue-based reference model
// tracks outstanding fetches (address + issue cycle) and predicts requests,
// addresses and delivered instructions from the fetch rules directly.
module tb_instr_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
  localparam logic [31:0] HI_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        req_hi;
  logic [31:0] addr_hi;
  logic [31:0] rdata_hi;
  logic        valid_hi;
  logic [31:0] instr_hi;
  logic [31:0] pc_hi;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] q_addr [$];
  int          q_cyc  [$];
  logic [31:0] m_next;
  int          m_cyc = 0;
  logic        exp_req;
  logic        exp_valid;
  logic [31:0] exp_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(HI_PC)) u_dut_hi (
    .clk(clk), .rst(rst),
    .imem_req(req_hi), .imem_addr(addr_hi), .imem_rdata(rdata_hi),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(valid_hi), .instr_ready(1'b1),
    .instr(instr_hi), .instr_pc(pc_hi)
  );

  // memory models: data only meaningful for a real request
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ MAGIC) : 32'($urandom);
    rdata_hi   <= req_hi ? (addr_hi ^ MAGIC) : 32'($urandom);
  end

  // one line per completed transfer
  always @(negedge clk) begin
    if (instr_valid && instr_ready)
      $display("xfer t=%0t pc=%h instr=%h", $time, instr_pc, instr);
  end

  task automatic model_eval();
    exp_req   = !rst && !redirect_valid && (q_addr.size() < DEPTH);
    exp_addr  = m_next;
    exp_valid = !rst && !redirect_valid && (q_addr.size() > 0) && (q_cyc[0] + 2 <= m_cyc);
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
    if (exp_valid) begin
      exp_pc    = q_addr[0];
      exp_instr = q_addr[0] ^ MAGIC;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      q_addr.delete();
      q_cyc.delete();
      m_next = 32'h0;
    end else if (redirect_valid) begin
      q_addr.delete();
      q_cyc.delete();
      m_next = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_valid && instr_ready) begin
        void'(q_addr.pop_front());
        void'(q_cyc.pop_front());
      end
      if (exp_req) begin
        q_addr.push_back(m_next);
        q_cyc.push_back(m_cyc);
        m_next = m_next + 32'd4;
      end
    end
    m_cyc++;
  endtask

  // apply inputs for this cycle, then wait to the sampling point
  task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    instr_ready    = rdy;
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (req_hi !== 1'b0) begin n_fail++; $display("FAIL reset_req_hi: got %b expected 0", req_hi); end
    advance();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid: got %b expected 0", instr_valid); end
    advance();
  endtask

  task automatic test_stream();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    advance();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_addr k=%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      if (k >= 2) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 2)) || instr !== (32'(4 * (k - 2)) ^ MAGIC)) begin
          n_fail++; $display("FAIL stream_instr k=%0d: got v=%b pc=%h instr=%h expected pc=%h", k, instr_valid, instr_pc, instr, 32'(4 * (k - 2)));
        end
      end else begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid k=%0d: got %b expected 0", k, instr_valid); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    int          ndel;
    logic [31:0] got [8];
    nreq = 0;
    ndel = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      if (imem_req === 1'b1) begin
        n_cmp++; if (imem_addr !== 32'(4 * nreq)) begin n_fail++; $display("FAIL bp_addr: got %h expected %h", imem_addr, 32'(4 * nreq)); end
        nreq++;
      end
      advance();
    end
    n_cmp++; if (nreq != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", nreq); end
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (instr_valid === 1'b1 && ndel < 8) begin
        got[ndel] = instr_pc;
        ndel++;
      end
      advance();
    end
    n_cmp++; if (ndel != 8) begin n_fail++; $display("FAIL bp_deliver_count: got %0d expected 8", ndel); end
    for (int i = 0; i < ndel; i++) begin
      n_cmp++; if (got[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_order i=%0d: got %h expected %h", i, got[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_kill();
    int          ndel;
    logic [31:0] got [4];
    ndel = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      advance();
    end
    // two buffered (0,4) and one in flight (8)
    drive(1'b0, 1'b1, 32'h100, 1'b1);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b expected 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", instr_valid); end
    advance();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (instr_valid === 1'b1 && ndel < 4) begin
        got[ndel] = instr_pc;
        ndel++;
      end
      advance();
    end
    n_cmp++; if (ndel != 4) begin n_fail++; $display("FAIL redir_count: got %0d expected 4", ndel); end
    for (int i = 0; i < ndel; i++) begin
      n_cmp++; if (got[i] !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL redir_order i=%0d: got %h expected %h", i, got[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_misaligned();
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 + 32'(4 * k)) begin
        n_fail++; $display("FAIL misal_addr k=%0d: got req=%b addr=%h expected %h", k, imem_req, imem_addr, 32'h100 + 32'(4 * k));
      end
      if (k == 2) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ MAGIC)) begin
          n_fail++; $display("FAIL misal_instr: got v=%b pc=%h instr=%h expected pc=00000100", instr_valid, instr_pc, instr);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] a;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      a = HI_PC + 32'(4 * k);
      n_cmp++; if (req_hi !== 1'b1 || addr_hi !== a) begin
        n_fail++; $display("FAIL wrap_addr k=%0d: got req=%b addr=%h expected %h", k, req_hi, addr_hi, a);
      end
      if (k >= 2) begin
        a = HI_PC + 32'(4 * (k - 2));
        n_cmp++; if (valid_hi !== 1'b1 || pc_hi !== a || instr_hi !== (a ^ MAGIC)) begin
          n_fail++; $display("FAIL wrap_instr k=%0d: got v=%b pc=%h instr=%h expected pc=%h", k, valid_hi, pc_hi, instr_hi, a);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midstream();
    int          ndel;
    logic [31:0] got [3];
    ndel = 0;
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    advance();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      advance();
    end
    // reset wins over a simultaneous redirect and ready
    drive(1'b1, 1'b1, 32'h200, 1'b1);
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs: got req=%b valid=%b expected 0/0", imem_req, instr_valid);
    end
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_addr: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (instr_valid === 1'b1 && ndel < 3) begin
        got[ndel] = instr_pc;
        ndel++;
      end
      advance();
    end
    n_cmp++; if (ndel != 3) begin n_fail++; $display("FAIL mid_count: got %0d expected 3", ndel); end
    for (int i = 0; i < ndel; i++) begin
      n_cmp++; if (got[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL mid_order i=%0d: got %h expected %h", i, got[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_random();
    logic        r;
    logic        rv;
    logic        rdy;
    logic [31:0] rp;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 24) == 0);
      rp  = 32'($urandom);
      rdy = ($urandom_range(0, 9) < 7);
      drive(r, rv, rp, rdy);
      n_cmp++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL rand_req c=%0d: got %b expected %b", c, imem_req, exp_req); end
      if (exp_req) begin
        n_cmp++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL rand_addr c=%0d: got %h expected %h", c, imem_addr, exp_addr); end
      end
      n_cmp++; if (instr_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, instr_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (instr_pc !== exp_pc || instr !== exp_instr) begin
          n_fail++; $display("FAIL rand_instr c=%0d: got pc=%h instr=%h expected pc=%h instr=%h", c, instr_pc, instr, exp_pc, exp_instr);
        end
      end
      advance();
    end
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    m_next         = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_kill();
    test_redirect_misaligned();
    test_reset_pc_wrap();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
